// File: rtl/evt_pkg.sv
// -----------------------------------------------------------------------------
// evt_pkg
//
// Purpose:
//   Shared definitions for the event indicator slice: the per-channel blink
//   FSM state encoding, small-sized defaults used when simulating, and a
//   helper that sizes the half-period timer.
//
// Contents:
//   evt_state_e    - IDLE=0, ON=1, OFF=2 (encoding 3 is unused)
//   HALF_SIM       - half-period used by simulation builds
//   BLINKS_SIM     - blink count used by simulation builds
//   timerWidth()   - bits needed to hold HALF-1, never less than 1
// -----------------------------------------------------------------------------
package evt_pkg;

  // Per-channel sequence state. The encoding is fixed so that waveform
  // viewers and any external decode agree on the numeric values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } evt_state_e;

  // Short timings so a whole blink sequence fits in a few dozen cycles.
  localparam int HALF_SIM   = 4;
  localparam int BLINKS_SIM = 2;

  // The timer counts HALF-1 down to 0, so $clog2(HALF) bits suffice.
  // HALF=1 would give zero bits, which is not a legal vector, so clamp to 1.
  function automatic int timerWidth(input int half);
    int w;
    w = $clog2(half);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/evt_blink_ch.sv
// -----------------------------------------------------------------------------
// evt_blink_ch
//
// Purpose:
//   One indicator channel. A single-cycle event strobe starts a sequence of
//   BLINKS on-phases separated by off-phases, each HALF cycles long. The
//   sequence always ends on an ON phase. A strobe arriving mid-sequence
//   restarts the sequence from the beginning.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pulse     in   event strobe
//   led       out  LED drive, active-high, registered
//   busy      out  sequence in progress, registered
//   busy_nxt  out  next-state value of busy, so the parent can register an
//                  aggregate that lines up with busy in the same cycle
// -----------------------------------------------------------------------------
module evt_blink_ch
  import evt_pkg::*;
#(
  parameter int HALF   = 25_000_000,
  parameter int BLINKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic led,
  output logic busy,
  output logic busy_nxt
);

  localparam int TW = timerWidth(HALF);
  localparam int BW = $clog2(BLINKS + 1);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(HALF - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINKS - 1);

  evt_state_e      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            led_q;
  logic            busy_q;

  // Next-state logic. A strobe wins over everything else, so a retrigger
  // in the same cycle that a phase would have ended still restarts cleanly.
  // The blink counter holds the number of ON phases still to come after the
  // current one; it is decremented when OFF hands back to ON, and the
  // sequence ends when an ON phase expires with the counter at zero.
  // The unused encoding 2'd3 falls into the default arm and behaves as IDLE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;

    if (pulse) begin
      state_d = ON;
      timer_d = TIMER_LOAD;
      blink_d = BLINK_LOAD;
    end else begin
      case (state_q)
        ON: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (blink_q != '0) begin
            state_d = OFF;
            timer_d = TIMER_LOAD;
          end else begin
            state_d = IDLE;
            timer_d = '0;
            blink_d = '0;
          end
        end
        OFF: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else begin
            state_d = ON;
            timer_d = TIMER_LOAD;
            blink_d = blink_q - BW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          blink_d = '0;
        end
      endcase
    end
  end

  assign busy_nxt = (state_d != IDLE);

  // State, timer, counter and the registered outputs. The outputs are
  // decoded from the next state so led/busy change in the same cycle the
  // state does, one cycle after the strobe is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      led_q   <= (state_d == ON);
      busy_q  <= busy_nxt;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: rtl/evt_indicator.sv
// -----------------------------------------------------------------------------
// evt_indicator
//
// Purpose:
//   Turns each conditioned button event (including the conditioned reset
//   event) into a visible LED blink sequence. Channels are fully independent:
//   no shared state, no arbitration.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pulse     in   [CH] event strobes, one per channel
//   led       out  [CH] LED drive, active-high, registered
//   busy      out  [CH] sequence in progress per channel, registered
//   any_busy  out  OR of busy, registered
// -----------------------------------------------------------------------------
module evt_indicator
  import evt_pkg::*;
#(
  parameter int CH     = 5,
  parameter int HALF   = 25_000_000,
  parameter int BLINKS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] pulse,
  output logic [CH-1:0] led,
  output logic [CH-1:0] busy,
  output logic          any_busy
);

  logic [CH-1:0] busy_nxt;
  logic          any_busy_q;

  // One self-contained blink channel per event line.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    evt_blink_ch #(
      .HALF   (HALF),
      .BLINKS (BLINKS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pulse    (pulse[i]),
      .led      (led[i]),
      .busy     (busy[i]),
      .busy_nxt (busy_nxt[i])
    );
  end

  // Aggregate busy is built from the channels' next-state busy so that the
  // registered result is cycle-aligned with the per-channel busy flags
  // rather than trailing them by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_busy_q <= 1'b0;
    end else begin
      any_busy_q <= |busy_nxt;
    end
  end

  assign any_busy = any_busy_q;

endmodule

// File: tb/tb_evt_indicator.sv
// -----------------------------------------------------------------------------
// tb_evt_indicator
//
// Directed bench for evt_indicator. A main instance runs with HALF=4,
// BLINKS=2 and five channels; a second single-channel instance runs with
// HALF=1, BLINKS=1 for the minimum-parameter case. Cycle n is the interval
// after the n-th rising edge of a scenario; inputs are driven and outputs
// sampled on the falling edge in the middle of each cycle.
// -----------------------------------------------------------------------------
module tb_evt_indicator;
  import evt_pkg::*;

  localparam int CH = 5;

  logic          clk;
  logic          rst;
  logic [CH-1:0] pulse;
  logic [CH-1:0] led;
  logic [CH-1:0] busy;
  logic          anyBusy;

  logic          edgePulse;
  logic          edgeLed;
  logic          edgeBusy;
  logic          edgeAnyBusy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  evt_indicator #(
    .CH     (CH),
    .HALF   (HALF_SIM),
    .BLINKS (BLINKS_SIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse),
    .led      (led),
    .busy     (busy),
    .any_busy (anyBusy)
  );

  evt_indicator #(
    .CH     (1),
    .HALF   (1),
    .BLINKS (1)
  ) dutEdge (
    .clk      (clk),
    .rst      (rst),
    .pulse    (edgePulse),
    .led      (edgeLed),
    .busy     (edgeBusy),
    .any_busy (edgeAnyBusy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter that defines cycle numbering.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] p, input logic e);
    pulse     = p;
    edgePulse = e;
  endtask

  task automatic startScenario();
    @(negedge clk);
    base = cyc;
  endtask

  task automatic gotoRel(input int n);
    int guard;
    guard = 0;
    while ((cyc < base + n) && (guard < 1000)) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    logic [CH-1:0] p;
    logic          e;

    rst = 1'b0;
    applyStimulus('0, 1'b0);

    // Reset state, and strobes ignored while reset is held.
    @(negedge clk);
    checkOutput("rst.led", 32'(led), 32'h0);
    checkOutput("rst.busy", 32'(busy), 32'h0);
    checkOutput("rst.anyBusy", 32'(anyBusy), 32'h0);
    checkOutput("rst.edgeBusy", 32'(edgeBusy), 32'h0);
    applyStimulus('1, 1'b1);
    @(negedge clk);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    checkOutput("rst.pulseIgnored", 32'(busy), 32'h0);
    checkOutput("rst.edgeIgnored", 32'(edgeBusy), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst.released", 32'({anyBusy, busy}), 32'h0);

    // Single pulse on ch0 at cycle 10.
    $display("[TB] single pulse");
    startScenario();
    for (int c = 1; c <= 24; c++) begin
      gotoRel(c);
      applyStimulus((c == 10) ? CH'(1) : '0, 1'b0);
      if (c >= 11) begin
        checkOutput($sformatf("s1.led0@%0d", c), 32'(led[0]), 32'(c inside {[11:14], [19:22]}));
        checkOutput($sformatf("s1.busy0@%0d", c), 32'(busy[0]), 32'(c inside {[11:22]}));
        checkOutput($sformatf("s1.others@%0d", c), 32'({led[4:1], busy[4:1]}), 32'h0);
        checkOutput($sformatf("s1.any@%0d", c), 32'(anyBusy), 32'(c inside {[11:22]}));
      end
    end

    // Retrigger on ch1 during its OFF phase.
    $display("[TB] retrigger");
    startScenario();
    for (int c = 1; c <= 30; c++) begin
      gotoRel(c);
      applyStimulus((c == 10 || c == 16) ? CH'(2) : '0, 1'b0);
      if (c >= 11) begin
        checkOutput($sformatf("s2.led1@%0d", c), 32'(led[1]), 32'(c inside {[11:14], [17:20], [25:28]}));
        checkOutput($sformatf("s2.busy1@%0d", c), 32'(busy[1]), 32'(c inside {[11:28]}));
      end
    end

    // Simultaneous pulses on ch2/ch4, then ch3 extends any_busy.
    $display("[TB] simultaneous");
    startScenario();
    for (int c = 1; c <= 29; c++) begin
      gotoRel(c);
      p = '0;
      if (c == 5) p = 5'b10100;
      if (c == 15) p = 5'b01000;
      applyStimulus(p, 1'b0);
      if (c >= 6) begin
        checkOutput($sformatf("s3.led2@%0d", c), 32'(led[2]), 32'(c inside {[6:9], [14:17]}));
        checkOutput($sformatf("s3.led4@%0d", c), 32'(led[4]), 32'(c inside {[6:9], [14:17]}));
        checkOutput($sformatf("s3.busy3@%0d", c), 32'(busy[3]), 32'(c inside {[16:27]}));
        checkOutput($sformatf("s3.any@%0d", c), 32'(anyBusy), 32'(c inside {[6:27]}));
      end
    end

    // Pulse held high on ch0 for cycles 10-13.
    $display("[TB] held pulse");
    startScenario();
    for (int c = 1; c <= 27; c++) begin
      gotoRel(c);
      applyStimulus((c inside {[10:13]}) ? CH'(1) : '0, 1'b0);
      if (c >= 11) begin
        checkOutput($sformatf("s4.led0@%0d", c), 32'(led[0]), 32'(c inside {[11:17], [22:25]}));
        checkOutput($sformatf("s4.busy0@%0d", c), 32'(busy[0]), 32'(c inside {[11:25]}));
      end
    end

    // Asynchronous reset mid-sequence, then a full sequence after release.
    $display("[TB] reset mid-sequence");
    startScenario();
    for (int c = 1; c <= 15; c++) begin
      gotoRel(c);
      applyStimulus((c == 10) ? CH'(1) : '0, 1'b0);
    end
    checkOutput("s5.led0@15", 32'(led[0]), 32'h0);
    checkOutput("s5.busy0@15", 32'(busy[0]), 32'h1);
    @(posedge clk);
    #3;
    checkOutput("s5.preRstBusy", 32'({anyBusy, busy[0]}), 32'h3);
    rst = 1'b0;
    #1;
    checkOutput("s5.rstLed", 32'(led), 32'h0);
    checkOutput("s5.rstBusy", 32'(busy), 32'h0);
    checkOutput("s5.rstAny", 32'(anyBusy), 32'h0);
    for (int c = 17; c <= 44; c++) begin
      gotoRel(c);
      if (c == 25) rst = 1'b1;
      applyStimulus((c == 18 || c == 30) ? CH'(1) : '0, 1'b0);
      if (c < 30) begin
        checkOutput($sformatf("s5.held@%0d", c), 32'({anyBusy, busy, led}), 32'h0);
      end else if (c >= 31) begin
        checkOutput($sformatf("s5.led0@%0d", c), 32'(led[0]), 32'(c inside {[31:34], [39:42]}));
        checkOutput($sformatf("s5.busy0@%0d", c), 32'(busy[0]), 32'(c inside {[31:42]}));
      end
    end

    // Minimum parameters on the edge instance, and a retrigger on the last
    // ON cycle of ch3 that keeps the LED continuously lit.
    $display("[TB] edge parameters and last-cycle retrigger");
    startScenario();
    for (int c = 1; c <= 36; c++) begin
      gotoRel(c);
      p = (c == 10 || c == 22) ? CH'(8) : '0;
      e = (c == 3);
      applyStimulus(p, e);
      if (c >= 4 && c <= 7) begin
        checkOutput($sformatf("s6.edgeLed@%0d", c), 32'(edgeLed), 32'(c == 4));
        checkOutput($sformatf("s6.edgeBusy@%0d", c), 32'({edgeAnyBusy, edgeBusy}), (c == 4) ? 32'h3 : 32'h0);
      end
      if (c >= 11) begin
        checkOutput($sformatf("s6.led3@%0d", c), 32'(led[3]), 32'(c inside {[11:14], [19:26], [31:34]}));
        checkOutput($sformatf("s6.busy3@%0d", c), 32'(busy[3]), 32'(c inside {[11:34]}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
